// File: rtl/mu0_pkg.sv
// Shared types and constants for the MU0 boot-loading memory slice.
package mu0_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 13;
  localparam logic [ADDR_W-1:0] IO_ADDR_DEF = 12'hFFF;

  typedef enum logic [1:0] {
    LOAD_HI,
    LOAD_LO,
    RUN,
    HALT
  } state_t;

endpackage

// File: rtl/mu0_ram.sv
// DEPTHx16 word store: one synchronous write port, asynchronous read, no reset.
module mu0_ram
  import mu0_pkg::*;
#(
  parameter int DEPTH = 4096
) (
  input  logic              Clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read address is independent of the write mux so the CPU can read during a load.
  assign rdata = mem[raddr];

endmodule

// File: rtl/mu0_boot_mem.sv
// Byte-stream boot loader in front of MU0 RAM, holding the core in reset until the image is in.
module mu0_boot_mem
  import mu0_pkg::*;
#(
  parameter logic [ADDR_W-1:0] IO_ADDR = IO_ADDR_DEF,
  parameter int                DEPTH   = 4096
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic [7:0]        ld_data,
  input  logic              ld_valid,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_reset,
  input  logic [ADDR_W-1:0] Addr,
  input  logic              Rd,
  input  logic              Wr,
  input  logic [DATA_W-1:0] DOut,
  output logic [DATA_W-1:0] DIn,
  input  logic              Halted,
  output logic [DATA_W-1:0] io_out,
  output logic              io_strobe,
  output logic [CNT_W-1:0]  words_loaded
);

  state_t            state;
  logic [CNT_W-1:0]  ptr;
  logic [7:0]        hi_byte;
  logic              xfer;
  logic              io_hit;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  assign xfer   = ld_valid && ld_ready;
  assign io_hit = (Addr == IO_ADDR);

  // The write port belongs to the loader until RUN, then to the CPU; HALT blocks both.
  assign ram_we    = ((state == LOAD_LO) && xfer) || ((state == RUN) && Wr && !io_hit);
  assign ram_waddr = (state == RUN) ? Addr : ptr[ADDR_W-1:0];
  assign ram_wdata = (state == RUN) ? DOut : {hi_byte, ld_data};

  mu0_ram #(.DEPTH(DEPTH)) u_ram (
    .Clk   (Clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (Addr),
    .rdata (ram_rdata)
  );

  // A simultaneous write masks the read data.
  assign DIn = (Rd && !Wr) ? (io_hit ? io_out : ram_rdata) : '0;

  assign words_loaded = ptr;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state     <= LOAD_HI;
      ptr       <= '0;
      hi_byte   <= '0;
      io_out    <= '0;
      io_strobe <= 1'b0;
      cpu_reset <= 1'b1;
      ld_ready  <= 1'b1;
    end else begin
      io_strobe <= 1'b0;
      case (state)
        LOAD_HI: begin
          if (xfer) begin
            hi_byte <= ld_data;
            state   <= LOAD_LO;
          end
        end
        LOAD_LO: begin
          if (xfer) begin
            ptr <= ptr + CNT_W'(1);
            // Stopping at the last RAM word keeps ptr from wrapping onto word 0.
            if (ld_last || (ptr == CNT_W'(DEPTH - 1))) begin
              state     <= RUN;
              ld_ready  <= 1'b0;
              cpu_reset <= 1'b0;
            end else begin
              state <= LOAD_HI;
            end
          end
        end
        RUN: begin
          if (Wr && io_hit) begin
            io_out    <= DOut;
            io_strobe <= 1'b1;
          end
          if (Halted) state <= HALT;
        end
        HALT: begin
          state <= HALT;
        end
        default: state <= LOAD_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_mu0_boot_mem.sv
// Directed bench for mu0_boot_mem: load handshake, CPU access, halt and reset-during-load.
module tb_mu0_boot_mem;
  import mu0_pkg::*;

  logic        Clk = 1'b0;
  logic        reset;
  logic [7:0]  ld_data;
  logic        ld_valid;
  logic        ld_last;
  logic        ld_ready;
  logic        cpu_reset;
  logic [11:0] Addr;
  logic        Rd;
  logic        Wr;
  logic [15:0] DOut;
  logic [15:0] DIn;
  logic        Halted;
  logic [15:0] io_out;
  logic        io_strobe;
  logic [12:0] words_loaded;

  int n_checks = 0;
  int n_errors = 0;

  mu0_boot_mem dut (
    .Clk          (Clk),
    .reset        (reset),
    .ld_data      (ld_data),
    .ld_valid     (ld_valid),
    .ld_last      (ld_last),
    .ld_ready     (ld_ready),
    .cpu_reset    (cpu_reset),
    .Addr         (Addr),
    .Rd           (Rd),
    .Wr           (Wr),
    .DOut         (DOut),
    .DIn          (DIn),
    .Halted       (Halted),
    .io_out       (io_out),
    .io_strobe    (io_strobe),
    .words_loaded (words_loaded)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    ld_data  = d;
    ld_last  = last;
    ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [15:0] exp);
    Addr = a;
    Rd   = 1'b1;
    #1;
    check(tag, DIn, exp);
    Rd = 1'b0;
    tick();
  endtask

  task automatic cpu_wr(input logic [11:0] a, input logic [15:0] d);
    Addr = a;
    DOut = d;
    Wr   = 1'b1;
    tick();
    Wr = 1'b0;
  endtask

  logic       v_tab [11] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
  logic [7:0] d_tab [11] = '{8'hA1, 8'hFF, 8'hB2, 8'hFF, 8'hC3, 8'hFF, 8'hD4, 8'h00, 8'hE5, 8'hFF, 8'hF6};
  logic       l_tab [11] = '{0, 1, 0, 1, 1, 1, 0, 1, 0, 1, 1};

  initial begin
    reset = 1'b1; ld_data = '0; ld_valid = 1'b0; ld_last = 1'b0;
    Addr = '0; Rd = 1'b0; Wr = 1'b0; DOut = '0; Halted = 1'b0;
    tick();
    check("rst_ld_ready", ld_ready, 1);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_words", words_loaded, 0);
    check("rst_io_out", io_out, 0);
    check("rst_io_strobe", io_strobe, 0);
    check("rst_din_idle", DIn, 0);
    reset = 1'b0;
    tick();

    // Basic 2-word image
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0);
    check("pre_last_cpu_reset", cpu_reset, 1);
    send_byte(8'h78, 1'b1);
    check("post_last_cpu_reset", cpu_reset, 0);
    check("post_last_ld_ready", ld_ready, 0);
    check("basic_words", words_loaded, 2);
    rd_chk("basic_ram0", 12'h000, 16'h1234);
    rd_chk("basic_ram1", 12'h001, 16'h5678);

    // CPU RAM and IO access in RUN
    cpu_wr(12'h010, 16'hABCD);
    rd_chk("run_ram010", 12'h010, 16'hABCD);
    Addr = 12'h010; DOut = 16'h1111; Rd = 1'b1; Wr = 1'b1;
    #1;
    check("rdwr_din_zero", DIn, 0);
    tick();
    Rd = 1'b0; Wr = 1'b0;
    rd_chk("rdwr_write_done", 12'h010, 16'h1111);
    cpu_wr(12'hFFF, 16'h0042);
    check("io_strobe_hi", io_strobe, 1);
    check("io_out_val", io_out, 16'h0042);
    tick();
    check("io_strobe_lo", io_strobe, 0);
    rd_chk("io_readback", 12'hFFF, 16'h0042);

    // Halt blocks further writes
    cpu_wr(12'h020, 16'h5555);
    Halted = 1'b1;
    tick();
    Halted = 1'b0;
    check("halt_state", dut.state, HALT);
    cpu_wr(12'h020, 16'hBEEF);
    cpu_wr(12'hFFF, 16'h7777);
    check("halt_io_strobe", io_strobe, 0);
    check("halt_io_out", io_out, 16'h0042);
    rd_chk("halt_ram020", 12'h020, 16'h5555);
    tick();
    check("halt_stays", dut.state, HALT);
    check("halt_ld_ready", ld_ready, 0);
    check("halt_cpu_reset", cpu_reset, 0);

    // Gapped valid, ld_last on a high byte ignored
    do_reset();
    for (int k = 0; k < 11; k++) begin
      ld_valid = v_tab[k];
      ld_data  = d_tab[k];
      ld_last  = l_tab[k];
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    check("gap_words", words_loaded, 3);
    check("gap_cpu_reset", cpu_reset, 0);
    rd_chk("gap_ram0", 12'h000, 16'hA1B2);
    rd_chk("gap_ram1", 12'h001, 16'hC3D4);
    rd_chk("gap_ram2", 12'h002, 16'hE5F6);

    // Reset between the bytes of word 3
    do_reset();
    send_byte(8'h0A, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'h0B, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h0C, 1'b0); send_byte(8'h03, 1'b0);
    send_byte(8'h0D, 1'b0);
    reset = 1'b1;
    #2;
    check("midrst_words", words_loaded, 0);
    check("midrst_cpu_reset", cpu_reset, 1);
    check("midrst_ld_ready", ld_ready, 1);
    check("midrst_state", dut.state, LOAD_HI);
    reset = 1'b0;
    tick();
    rd_chk("midrst_ram0", 12'h000, 16'h0A01);
    rd_chk("midrst_ram1", 12'h001, 16'h0B02);
    rd_chk("midrst_ram2", 12'h002, 16'h0C03);
    send_byte(8'hEE, 1'b0);
    send_byte(8'hEF, 1'b1);
    check("reload_words", words_loaded, 1);
    rd_chk("reload_ram0", 12'h000, 16'hEEEF);
    rd_chk("reload_ram1", 12'h001, 16'h0B02);

    // Full-depth image without ld_last
    do_reset();
    for (int i = 0; i < 4096; i++) begin
      logic [15:0] w;
      w = 16'(i) ^ 16'h5A5A;
      if (i == 4095) begin
        check("full_pre_words", words_loaded, 4095);
        check("full_pre_ready", ld_ready, 1);
      end
      send_byte(w[15:8], 1'b0);
      send_byte(w[7:0], 1'b0);
    end
    check("full_words", words_loaded, 4096);
    check("full_ld_ready", ld_ready, 0);
    check("full_cpu_reset", cpu_reset, 0);
    check("full_state", dut.state, RUN);
    ld_data = 8'h99; ld_valid = 1'b1;
    tick();
    tick();
    ld_valid = 1'b0;
    check("full_no_wrap_words", words_loaded, 4096);
    rd_chk("full_ram0", 12'h000, 16'h5A5A);
    rd_chk("full_ram800", 12'h800, 16'h525A);
    rd_chk("full_ramFFE", 12'hFFE, 16'h55A4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
